// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port synchronous memory.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   {a,b}_req/_we/_addr/_wdata       requests; held stable until the matching gnt
//   {a,b}_gnt                        one-cycle grant pulse (WR or RD state)
//   {a,b}_rvalid/_rdata              one-cycle read strobe; rdata holds until the next read
//   mem_read/_write/_addr/_data_in   memory command; memory returns mem_data_out next cycle
//   busy                             high outside IDLE
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority (a wins ties)
// instead of round-robin.
module mem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, WR, RD, RDCAP} state_t;
    state_t state, state_nxt;
    // sel is the current winner (0=a, 1=b); in round-robin it doubles as the
    // last-winner pointer. Reset to b so a wins the first tie.
    logic sel, sel_nxt, any_req, win_we;
    assign any_req = a_req | b_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
    assign sel_nxt = ~a_req;
`else
    assign sel_nxt = (a_req & b_req) ? ~sel : b_req;
`endif
    assign win_we = sel_nxt ? b_we : a_we;
    always_comb begin
        state_nxt = state;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = state != IDLE;
        case (state)
            IDLE:  state_nxt = any_req ? (win_we ? WR : RD) : IDLE;
            WR: begin
                state_nxt = IDLE;
                mem_write = 1'b1;
                a_gnt     = ~sel;
                b_gnt     = sel;
            end
            RD: begin
                state_nxt = RDCAP;
                mem_read  = 1'b1;
                a_gnt     = ~sel;
                b_gnt     = sel;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= 1'b1;
            mem_addr    <= '0;
            mem_data_in <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_rvalid <= state == RDCAP && !sel;
            b_rvalid <= state == RDCAP && sel;
            if (state == IDLE && any_req) begin
                sel         <= sel_nxt;
                mem_addr    <= sel_nxt ? b_addr : a_addr;
                mem_data_in <= sel_nxt ? b_wdata : a_wdata;
            end
            if (state == RDCAP && !sel) a_rdata <= mem_data_out;
            if (state == RDCAP && sel) b_rdata <= mem_data_out;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a behavioural memory.
module tb_mem_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [4:0] a_addr = 0, b_addr = 0;
    logic [7:0] a_wdata = 0, b_wdata = 0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, mem_read, mem_write, busy;
    logic [7:0] a_rdata, b_rdata, mem_data_in, mem_data_out;
    logic [4:0] mem_addr;
    logic [7:0] mem [32];
    int passed = 0, total = 0;

    mem_arbiter #(.AW(5), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: samples command on posedge, read data appears the following cycle.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem_read ? mem[mem_addr] : 8'h00;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic reset_dut();
        a_req = 0; b_req = 0;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
    endtask

    // One transaction from IDLE by a single master; starts and ends on a negedge in IDLE.
    task automatic xact(input logic b, input logic we, input logic [4:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp);
        logic [7:0] keep;
        keep = b ? a_rdata : b_rdata;
        if (b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        @(negedge clk);
        chk("gnt", {a_gnt, b_gnt}, {!b, b});
        chk("mem_cmd", {mem_write, mem_read, mem_addr}, {we, !we, addr});
        a_req = 0; b_req = 0;
        @(negedge clk);
        if (!we) begin
            chk("rvalid_early", {a_rvalid, b_rvalid, busy}, 3'b001);
            @(negedge clk);
            chk("rvalid", {a_rvalid, b_rvalid, busy}, {!b, b, 1'b0});
            chk("rdata", b ? b_rdata : a_rdata, exp);
            chk("rdata_other_hold", b ? a_rdata : b_rdata, keep);
        end else chk("wr_done_idle", {busy, a_rvalid, b_rvalid}, 3'b000);
    endtask

    typedef struct {
        logic       b;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t vecs [8];
        logic bad;
        vecs[0] = '{0, 1, 5'd7,  8'h3C, 8'h00};
        vecs[1] = '{1, 1, 5'd9,  8'hC3, 8'h00};
        vecs[2] = '{1, 0, 5'd7,  8'h00, 8'h3C};
        vecs[3] = '{0, 0, 5'd9,  8'h00, 8'hC3};
        vecs[4] = '{0, 1, 5'd31, 8'hFF, 8'h00};
        vecs[5] = '{1, 1, 5'd0,  8'h81, 8'h00};
        vecs[6] = '{1, 0, 5'd31, 8'h00, 8'hFF};
        vecs[7] = '{0, 0, 5'd0,  8'h00, 8'h81};

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_read, mem_write, busy}, 7'b0);
        chk("reset_data", {mem_addr, mem_data_in, a_rdata, b_rdata}, 29'b0);
        rst_n = 1;

        for (int i = 0; i < 8; i++)
            xact(vecs[i].b, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        for (int i = 0; i < 32; i++) xact(0, 1, 5'(i), 8'h00, 8'h00);
        for (int i = 0; i < 32; i++) xact(0, 0, 5'(i), 8'h00, 8'h00);

        for (int i = 0; i < 32; i++) xact(1, 1, 5'(i), 8'(i), 8'h00);
        for (int i = 0; i < 32; i++) xact(0, 0, 5'(i), 8'h00, 8'(i));

        // Continuous simultaneous writes from both masters after reset.
        reset_dut();
        a_req = 1; a_we = 1; a_addr = 5'd10; a_wdata = 8'h01;
        b_req = 1; b_we = 1; b_addr = 5'd11; b_wdata = 8'h02;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
            chk("tie_gnt", {a_gnt, b_gnt}, c % 2 == 0 ? 2'b10 : 2'b00);
`else
            chk("tie_gnt", {a_gnt, b_gnt}, c % 2 == 1 ? 2'b00 : ((c / 2) % 2 == 0 ? 2'b10 : 2'b01));
`endif
        end

        // a writes addr 5 while b reads addr 5 in the same cycle.
        reset_dut();
        a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 8'hA5;
        b_req = 1; b_we = 0; b_addr = 5'd5;
        @(negedge clk);
        chk("race_a_first", {a_gnt, b_gnt}, 2'b10);
        a_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("race_b_second", {a_gnt, b_gnt, mem_read}, 3'b011);
        b_req = 0;
        @(negedge clk);
        @(negedge clk);
        chk("race_b_rdata", {b_rvalid, b_rdata}, {1'b1, 8'hA5});

        // Reset during a read of addr 3.
        reset_dut();
        a_req = 1; a_we = 0; a_addr = 5'd3;
        @(negedge clk);
        chk("rst_pre_gnt", {a_gnt, mem_read, mem_addr}, {2'b11, 5'd3});
        #2 rst_n = 0;
        #1 chk("rst_async", {a_gnt, b_gnt, busy, mem_read, mem_write, mem_addr, a_rdata}, 18'b0);
        a_req = 0;
        @(negedge clk); rst_n = 1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            bad |= a_rvalid | b_rvalid | busy | a_gnt;
        end
        chk("rst_no_rvalid", bad, 1'b0);

        // a requests while b's read is in RD.
        b_req = 1; b_we = 0; b_addr = 5'd9;
        @(negedge clk);
        chk("wait_b_gnt", {a_gnt, b_gnt}, 2'b01);
        b_req = 0;
        a_req = 1; a_we = 0; a_addr = 5'd12;
        @(negedge clk);
        chk("wait_rdcap", {a_gnt, busy}, 2'b01);
        @(negedge clk);
        chk("wait_idle", {a_gnt, b_rvalid, b_rdata}, {2'b01, 8'd9});
        @(negedge clk);
        chk("wait_a_gnt", {a_gnt, b_gnt}, 2'b10);
        a_req = 0;
        repeat (2) @(negedge clk);
        chk("wait_a_rdata", {a_rvalid, a_rdata}, {1'b1, 8'd12});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
